// File: rtl/div_unit.sv
// Signed 32-bit iterative divider: MIPS DIV semantics, one restoring step per cycle.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 5;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Run  = 2'd1,
        Fix  = 2'd2,
        Zero = 2'd3
    } divStateT;

    divStateT stateQ;
    divStateT stateNext;

    logic [DataW-1:0] quoQ;
    logic [DataW-1:0] remQ;
    logic [DataW:0]   divQ;
    logic [CntW-1:0]  countQ;
    logic             qNegQ;
    logic             rNegQ;

    logic             divisorZero;
    logic             accept;
    logic [DataW-1:0] absDividend;
    logic [DataW-1:0] absDivisor;
    logic [DataW:0]   shifted;
    logic             stepGeq;
    logic [DataW-1:0] remStep;
    logic [DataW-1:0] quoFinal;
    logic [DataW-1:0] remFinal;

    assign divisorZero = (divisor == '0);
    assign accept      = (stateQ == Idle) && start && !divisorZero;

    // Magnitudes; 0x80000000 maps to the unsigned value 2^31.
    assign absDividend = dividend[DataW-1] ? DataW'(-dividend) : dividend;
    assign absDivisor  = divisor[DataW-1]  ? DataW'(-divisor)  : divisor;

    // One restoring step on the 33-bit partial remainder.
    always_comb begin
        shifted = {remQ, quoQ[DataW-1]};
        stepGeq = (shifted >= divQ);
        remStep = stepGeq ? DataW'(shifted - divQ) : shifted[DataW-1:0];
    end

    // Sign correction applied while in FIX.
    always_comb begin
        quoFinal = qNegQ ? DataW'(-quoQ) : quoQ;
        remFinal = rNegQ ? DataW'(-remQ) : remQ;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= Idle;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            Idle: begin
                if (start) begin
                    stateNext = divisorZero ? Zero : Run;
                end
            end
            Run: begin
                if (countQ == CntW'(DataW - 1)) begin
                    stateNext = Fix;
                end
            end
            Fix:     stateNext = Idle;
            Zero:    stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quoQ   <= '0;
            remQ   <= '0;
            divQ   <= '0;
            countQ <= '0;
            qNegQ  <= 1'b0;
            rNegQ  <= 1'b0;
        end else if (accept) begin
            quoQ   <= absDividend;
            remQ   <= '0;
            divQ   <= {1'b0, absDivisor};
            countQ <= '0;
            qNegQ  <= dividend[DataW-1] ^ divisor[DataW-1];
            rNegQ  <= dividend[DataW-1];
        end else if (stateQ == Run) begin
            remQ   <= remStep;
            quoQ   <= {quoQ[DataW-2:0], stepGeq};
            countQ <= countQ + CntW'(1);
        end
    end

    // Registered status pulses and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            busy     <= (stateNext != Idle);
            done     <= (stateQ == Fix);
            div_zero <= (stateNext == Zero);
            if (stateQ == Fix) begin
                lo <= quoFinal;
                hi <= remFinal;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signs, divide-by-zero, reset abort, back-to-back.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eLo;
        logic [31:0] eHi;
    } vecT;

    vecT vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller is 1 time unit past a rising edge (cycle 0). Operands are scrambled after acceptance.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eLo, input logic [31:0] eHi,
                         input string nm, input int glitchAt, input bit chain,
                         input logic [31:0] na, input logic [31:0] nb);
        int busyErr;
        int doneCyc;
        int doneCnt;
        int zeroCnt;
        busyErr = 0;
        doneCyc = -1;
        doneCnt = 0;
        zeroCnt = 0;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clock);
            #1;
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            if (c == glitchAt) begin
                start    = 1'b1;
                dividend = 32'd1000;
                divisor  = 32'd0;
            end
            if (c == 34 && chain) begin
                start    = 1'b1;
                dividend = na;
                divisor  = nb;
            end
            @(negedge clock);
            if (busy !== (c <= 33)) busyErr++;
            if (done === 1'b1) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (div_zero !== 1'b0) zeroCnt++;
        end
        check({nm, " busy"}, 32'(busyErr), 32'd0);
        check({nm, " done cycle"}, 32'(doneCyc), 32'd34);
        check({nm, " done count"}, 32'(doneCnt), 32'd1);
        check({nm, " div_zero"}, 32'(zeroCnt), 32'd0);
        check({nm, " lo"}, lo, eLo);
        check({nm, " hi"}, hi, eHi);
        if (!chain) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int doneSeen;
        int busySeen;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2]  = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[4]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0};
        vecs[5]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0};
        vecs[7]  = '{32'd3,          32'd10,         32'd0,          32'd3};
        vecs[8]  = '{32'hFFFFFFFF,   32'h80000000,   32'd0,          32'hFFFFFFFF};
        vecs[9]  = '{32'h7FFFFFFF,   32'h7FFFFFFF,   32'd1,          32'd0};
        vecs[10] = '{32'h80000000,   32'h80000000,   32'd1,          32'd0};
        vecs[11] = '{32'd12345678,   32'hFFFFFC18,   32'hFFFFCFC7,   32'h000002A6};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1 reset = 1'b0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset div_zero", 32'(div_zero), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        #10 reset = 1'b1;
        @(posedge clock);
        #1;

        // Vector table, back to back with one idle cycle between.
        for (int i = 0; i < 12; i++) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].eLo, vecs[i].eHi,
                  $sformatf("vec%0d", i), 0, 1'b0, 32'd0, 32'd0);
        end

        // Divide by zero: one-cycle div_zero, results untouched.
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd0;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("dz cyc1 div_zero", 32'(div_zero), 32'd1);
        check("dz cyc1 busy", 32'(busy), 32'd1);
        check("dz cyc1 done", 32'(done), 32'd0);
        @(negedge clock);
        check("dz cyc2 div_zero", 32'(div_zero), 32'd0);
        check("dz cyc2 busy", 32'(busy), 32'd0);
        doneSeen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (done !== 1'b0 || div_zero !== 1'b0) doneSeen++;
        end
        check("dz no pulses", 32'(doneSeen), 32'd0);
        check("dz lo held", lo, 32'hFFFFCFC7);
        check("dz hi held", hi, 32'h000002A6);
        @(posedge clock);
        #1;

        // Asynchronous reset in cycle 20 of a division, then a fresh request.
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort div_zero", 32'(div_zero), 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        #3 reset = 1'b1;
        doneSeen = 0;
        busySeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done !== 1'b0) doneSeen++;
            if (busy !== 1'b0) busySeen++;
        end
        check("abort no done", 32'(doneSeen), 32'd0);
        check("abort idle", 32'(busySeen), 32'd0);
        check("abort lo kept 0", lo, 32'd0);
        @(posedge clock);
        #1;
        runOp(32'd9, 32'd3, 32'd3, 32'd0, "post-reset 9/3", 0, 1'b0, 32'd0, 32'd0);

        // Start during RUN ignored; start in the done cycle accepted.
        runOp(32'd20, 32'd3, 32'd6, 32'd2, "b2b first", 10, 1'b1, 32'd50, 32'd5);
        runOp(32'd50, 32'd5, 32'd10, 32'd0, "b2b second", 0, 1'b0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clock  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately, independent of clock).
REQ-003 start  input  1  one-cycle request from control unit (DivCtrl); sampled only in IDLE.
REQ-004 dividend  input  32  signed dividend (register A); sampled on the accepting edge only.
REQ-005 divisor  input  32  signed divisor (register B); sampled on the accepting edge only.
REQ-006 busy  output  1  high in every state other than IDLE.
REQ-007 done  output  1  one-cycle pulse: hi/lo updated with a new result.
REQ-008 div_zero  output  1  one-cycle pulse: request rejected, divisor was zero.
REQ-009 hi  output  32  remainder of the last completed division (feeds HI mux).
REQ-010 lo  output  32  quotient of the last completed division (feeds LO mux).

Function
REQ-011 States SHALL be IDLE, RUN, FIX, ZERO; the state encoding is registered.
REQ-012 In IDLE, start=1 and divisor!=0 SHALL capture |dividend|, |divisor|, the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]), clear the remainder accumulator and the 5-bit counter, and go to RUN.
REQ-013 In IDLE, start=1 and divisor==0 SHALL go to ZERO; hi/lo SHALL be unchanged.
REQ-014 ZERO SHALL last one cycle with div_zero=1, then return to IDLE.
REQ-015 RUN SHALL perform one unsigned restoring step per cycle: shift {rem,quo} left 1, subtract |divisor| from the 33-bit partial remainder, keep the result and set the quotient LSB when it is non-negative, otherwise restore and clear the LSB.
REQ-016 RUN SHALL last exactly 32 cycles; on the edge where counter==31 the state SHALL go to FIX.
REQ-017 FIX SHALL negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set, load lo/hi on the exit edge, pulse done in the following cycle, and return to IDLE.
REQ-018 Latency: start high in cycle 0 SHALL give done=1 in cycle 34 exactly; hi/lo SHALL be valid from cycle 34 and hold until the next done.
REQ-019 Semantics SHALL match MIPS DIV: the quotient truncates toward zero; the remainder takes the dividend sign; |remainder| < |divisor|.
REQ-020 |x| of 0x80000000 SHALL be computed as the unsigned value 2^31; the datapath is 33 bits wide, so this value does not overflow.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000 (the quotient wraps); no flag is raised.
REQ-022 start asserted while busy=1 SHALL be ignored; it is not queued and has no effect on the operation in progress.
REQ-023 The dividend and divisor inputs SHALL be don't-care after the accepting edge; changing them mid-operation SHALL NOT affect the result.
REQ-024 done and div_zero SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per event.
REQ-025 start in the cycle where done=1 (state IDLE) SHALL be accepted normally, so back-to-back operations are possible.

Reset
REQ-026 reset=0 SHALL force state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0 and counter=0 asynchronously, including during RUN or FIX.
REQ-027 A division interrupted by reset SHALL be discarded: no done pulse and no hi/lo update after reset is released.
REQ-028 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-029 dividend=100, divisor=7, start pulse in cycle 0 -> busy high in cycles 1-33, done in cycle 34, lo=14, hi=2.
REQ-030 dividend=-7 (0xFFFFFFF9), divisor=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); dividend=7, divisor=-2 -> lo=-3, hi=1.
REQ-031 dividend=5, divisor=0 -> div_zero=1 in cycle 1 only, done never high, hi/lo keep their prior values, busy high in cycle 1 only.
REQ-032 dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0; dividend=0x80000000, divisor=1 -> lo=0x80000000, hi=0.
REQ-033 reset=0 driven asynchronously (not aligned to a clock edge) in cycle 20 of a division -> all outputs 0 immediately; release reset; no done pulse follows; a new 9/3 request -> lo=3, hi=0 after 34 cycles.
REQ-034 start pulsed again in cycle 10 of an active division, then start pulsed in the cycle where done=1 -> the cycle-10 start is ignored and the second operation is accepted, with its done exactly 34 cycles later.
